lane_draw_scheduler: RTL and testbench
======================================

LANE_DRAW_SCHEDULER -- requirements
Module: lane_draw_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- X_BASE, 8, x of slot 0 left column.
- ROW, 53, y of lane top row.
- SLOT_PITCH, 8, x distance between slots.
- FLASH_X, 8, x of hit-flash square.
- FLASH_Y, 46, y of hit-flash square.
- NOTE_COLOUR, 3'b100, colour of an occupied slot.
- BG_COLOUR, 3'b000, colour of an empty slot.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock (CLOCK_50 domain).
- reset, in, 1, synchronous, active-high.
- beat, in, 1, one-cycle lane-redraw request.
- notes, in, 10, note pattern; bit i occupies slot i.
- flash_req, in, 1, level request for a hit flash; held until flash_ack.
- flash_colour, in, 3, flash colour, sampled on grant.
- flash_ack, out, 1, one-cycle pulse when the flash is complete.
- x, out, 8, VGA pixel x.
- y, out, 7, VGA pixel y.
- colour, out, 3, VGA pixel colour.
- plot, out, 1, pixel write enable.
- busy, out, 1, high in LANE or FLASH.
- frame_done, out, 1, one-cycle pulse after the last lane pixel.
- overrun_count, out, 8, dropped-beat counter (see Configuration).
REQ-003 One clock domain; reset is synchronous and active-high; all outputs registered.

Function
REQ-004 The FSM has states IDLE, LANE and FLASH; busy is 1 exactly when the state is LANE or FLASH.
REQ-005 Granting LANE latches notes into note_q and clears slot and pixel counters; later changes to notes do not affect that frame.
REQ-006 LANE emits one pixel per cycle for 160 cycles, ordered slot 0..9 and pixel 0..15 within each slot.
REQ-007 LANE pixel coordinates: x = X_BASE + slot*SLOT_PITCH + pix[1:0]; y = ROW + pix[3:2].
REQ-008 LANE pixel colour is NOTE_COLOUR when note_q[slot] is 1, else BG_COLOUR.
REQ-009 Granting FLASH latches flash_colour; FLASH emits 16 pixels at x = FLASH_X + pix[1:0], y = FLASH_Y + pix[3:2].
REQ-010 Latency: a grant decided in cycle N gives its first plot=1 in cycle N+1; plot is 0 in every cycle with no pixel.
REQ-011 frame_done pulses in the cycle after the 160th LANE plot; flash_ack pulses in the cycle after the 16th FLASH plot.
REQ-012 Requests are arbitrated at each decision point: IDLE, or the completion cycle of LANE or FLASH.
REQ-013 Lane requests are beat seen in IDLE or a pending beat; flash requests are flash_req=1.
REQ-014 Ties are round-robin: the type not served last wins; after reset LANE wins.
REQ-015 If a request is granted at a completion cycle, the next burst starts with no IDLE cycle between bursts.
REQ-016 A beat arriving while busy sets a one-deep pending flag; pending is cleared when LANE is granted.
REQ-017 A beat arriving while pending is already set is dropped.
REQ-018 Pixel arithmetic is unsigned; x truncates to 8 bits and y to 7 bits; no bounds clipping.

Reset
REQ-019 Reset puts the FSM in IDLE and clears note_q, counters, pending and latched colour.
REQ-020 Reset sets x, y, colour, plot, busy, frame_done, flash_ack and overrun_count to 0, and sets last-served to FLASH.
REQ-021 Reset mid-burst aborts the burst: plot=0 the next cycle, with no frame_done or flash_ack.

Configuration
REQ-022 With macro LANE_OVERRUN_CNT_EN defined, overrun_count increments by 1 per dropped beat and saturates at 255.
REQ-023 Without LANE_OVERRUN_CNT_EN, overrun_count is constant 0 and no counter logic is built.

Verification
REQ-024 Reset, then beat with notes=10'b0000000001 -> 160 plots; first pixel (8,53) colour 100; 17th pixel (16,53) colour 000; last pixel (83,56); frame_done the next cycle.
REQ-025 Idle, flash_req=1, flash_colour=010 -> 16 plots from (8,46) to (11,49) colour 010; flash_ack after the 16th plot; req then dropped -> IDLE.
REQ-026 Reset, then beat and flash_req in the same cycle -> 160 LANE plots, then 16 FLASH plots back-to-back with no gap.
REQ-027 Beat during LANE plus 2 further beats -> a second LANE follows directly; one beat dropped; overrun_count=1 with the macro, 0 without.
REQ-028 Reset at the 50th LANE plot -> next cycle plot=0, busy=0, frame_done never pulses; a new beat restarts at (8,53).
REQ-029 notes changed to 10'h3FF mid-LANE -> every slot drawn from the original snapshot.

Source files
------------

// File: rtl/lane_draw_scheduler.sv
// rtl/lane_draw_scheduler.sv - lane/flash pixel burst scheduler for a VGA plotter
// Optional build macro: LANE_OVERRUN_CNT_EN enables the dropped-beat counter on overrun_count.
module lane_draw_scheduler #(
  parameter int         X_BASE      = 8,
  parameter int         ROW         = 53,
  parameter int         SLOT_PITCH  = 8,
  parameter int         FLASH_X     = 8,
  parameter int         FLASH_Y     = 46,
  parameter logic [2:0] NOTE_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat,
  input  logic [9:0] notes,
  input  logic       flash_req,
  input  logic [2:0] flash_colour,
  output logic       flash_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] overrun_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LANE  = 2'd1,
    S_FLASH = 2'd2
  } state_t;

  // The state and counters always describe the pixel currently on the outputs,
  // so the completion cycle of a burst is the cycle its last pixel is shown.
  state_t     state, state_n;
  logic [3:0] slot, slot_n;
  logic [3:0] pix, pix_n;
  logic [9:0] note_q, note_n;
  logic [2:0] fcol_q, fcol_n;
  logic       pending, pending_n;
  logic       last_flash, last_flash_n;

  logic       lane_done;
  logic       flash_done;
  logic       decide;
  logic       lane_req;
  logic       flash_want;
  logic       grant_lane;
  logic       grant_flash;

  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic       plot_d;
  logic       busy_d;
  logic       frame_done_d;
  logic       flash_ack_d;

  // State register: FSM state, burst counters, snapshots and arbitration history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      slot       <= 4'd0;
      pix        <= 4'd0;
      note_q     <= 10'd0;
      fcol_q     <= 3'd0;
      pending    <= 1'b0;
      last_flash <= 1'b1;
    end else begin
      state      <= state_n;
      slot       <= slot_n;
      pix        <= pix_n;
      note_q     <= note_n;
      fcol_q     <= fcol_n;
      pending    <= pending_n;
      last_flash <= last_flash_n;
    end
  end

  // Next-state: arbitrate at decision points, otherwise step through the burst.
  always_comb begin
    state_n      = state;
    slot_n       = slot;
    pix_n        = pix;
    note_n       = note_q;
    fcol_n       = fcol_q;
    last_flash_n = last_flash;
    grant_lane   = 1'b0;
    grant_flash  = 1'b0;

    lane_done  = (state == S_LANE) && (slot == 4'd9) && (pix == 4'd15);
    flash_done = (state == S_FLASH) && (pix == 4'd15);
    decide     = (state == S_IDLE) || lane_done || flash_done;
    lane_req   = ((state == S_IDLE) && beat) || pending;
    // The flash being served still holds its request until it sees the ack,
    // so it must not re-arm itself at its own completion.
    flash_want = flash_req && (state != S_FLASH);

    if (decide) begin
      if (lane_req && flash_want) begin
        grant_lane  = last_flash;
        grant_flash = !last_flash;
      end else begin
        grant_lane  = lane_req;
        grant_flash = flash_want;
      end
    end

    if (grant_lane) begin
      state_n      = S_LANE;
      slot_n       = 4'd0;
      pix_n        = 4'd0;
      note_n       = notes;
      last_flash_n = 1'b0;
    end else if (grant_flash) begin
      state_n      = S_FLASH;
      slot_n       = 4'd0;
      pix_n        = 4'd0;
      fcol_n       = flash_colour;
      last_flash_n = 1'b1;
    end else if (decide) begin
      state_n = S_IDLE;
    end else begin
      pix_n = pix + 4'd1;
      if ((state == S_LANE) && (pix == 4'd15)) begin
        slot_n = slot + 4'd1;
      end
    end

    // An IDLE beat that loses arbitration is remembered the same way as a busy one.
    if (grant_lane) begin
      pending_n = 1'b0;
    end else begin
      pending_n = pending | beat;
    end
  end

  // Output decode: pixel for the cycle after this one, from the next-state values.
  always_comb begin
    x_d          = x;
    y_d          = y;
    colour_d     = colour;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = lane_done;
    flash_ack_d  = flash_done;
    case (state_n)
      S_LANE: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = 8'(X_BASE) + 8'(slot_n) * 8'(SLOT_PITCH) + {6'd0, pix_n[1:0]};
        y_d      = 7'(ROW) + {5'd0, pix_n[3:2]};
        colour_d = note_n[slot_n] ? NOTE_COLOUR : BG_COLOUR;
      end
      S_FLASH: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = 8'(FLASH_X) + {6'd0, pix_n[1:0]};
        y_d      = 7'(FLASH_Y) + {5'd0, pix_n[3:2]};
        colour_d = fcol_n;
      end
      default: begin
        plot_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Output register: every VGA-facing and status output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      flash_ack  <= 1'b0;
    end else begin
      x          <= x_d;
      y          <= y_d;
      colour     <= colour_d;
      plot       <= plot_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      flash_ack  <= flash_ack_d;
    end
  end

`ifdef LANE_OVERRUN_CNT_EN
  logic [7:0] ovr_q;
  logic       beat_drop;

  assign beat_drop = beat && (state != S_IDLE) && pending;

  // Saturating count of beats lost because one was already pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 8'd0;
    end else if (beat_drop && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_count = ovr_q;
`else
  assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_lane_draw_scheduler.sv
// tb/tb_lane_draw_scheduler.sv - self-checking bench for lane_draw_scheduler
module tb_lane_draw_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat = 1'b0;
  logic [9:0] notes = 10'd0;
  logic       flash_req = 1'b0;
  logic [2:0] flash_colour = 3'd0;
  logic       flash_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_count;

  always #5 clk = ~clk;

  lane_draw_scheduler dut (
    .clk(clk),
    .reset(reset),
    .beat(beat),
    .notes(notes),
    .flash_req(flash_req),
    .flash_colour(flash_colour),
    .flash_ack(flash_ack),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .frame_done(frame_done),
    .overrun_count(overrun_count)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int ack_cnt = 0;
  int fd_cyc = 0;
  int log_px[$];
  int log_cy[$];
  int base;
  int fd0;

  // Model: kind 0 = idle, 1 = lane, 2 = flash; idx = pixel number within the burst.
  int         m_kind = 0;
  int         m_idx = 0;
  logic [9:0] m_notes = 10'd0;
  int         m_col = 0;
  bit         m_pend = 0;
  int         m_last = 2;
  int         m_ovr = 0;
  bit         m_fd = 0;
  bit         m_fa = 0;

  function automatic int pk(input int px, input int py, input int pc);
    return (px << 10) | (py << 3) | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs that the DUT samples.
  task automatic model_step();
    bit decide;
    bit lreq;
    bit freq;
    int g;
    if (reset) begin
      m_kind = 0; m_idx = 0; m_notes = 10'd0; m_col = 0;
      m_pend = 0; m_last = 2; m_ovr = 0; m_fd = 0; m_fa = 0;
    end else begin
      m_fd   = (m_kind == 1) && (m_idx == 159);
      m_fa   = (m_kind == 2) && (m_idx == 15);
      decide = (m_kind == 0) || m_fd || m_fa;
      lreq   = ((m_kind == 0) && beat) || m_pend;
      freq   = flash_req && (m_kind != 2);
      g = 0;
      if (decide) begin
        if (lreq && freq) g = (m_last == 1) ? 2 : 1;
        else if (lreq) g = 1;
        else if (freq) g = 2;
      end
      if (beat && (m_kind != 0) && m_pend && (m_ovr < 255)) m_ovr++;
      if (g == 1) m_pend = 0;
      else if (beat) m_pend = 1;
      if (g == 1) begin
        m_kind = 1; m_idx = 0; m_notes = notes; m_last = 1;
      end else if (g == 2) begin
        m_kind = 2; m_idx = 0; m_col = flash_colour; m_last = 2;
      end else if (decide) begin
        m_kind = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_cycle();
    int s;
    int p;
    int ex;
    int ey;
    int ec;
    cyc++;
    chk("plot", plot, (m_kind != 0));
    chk("busy", busy, (m_kind != 0));
    chk("frame_done", frame_done, m_fd);
    chk("flash_ack", flash_ack, m_fa);
`ifdef LANE_OVERRUN_CNT_EN
    chk("overrun_count", overrun_count, m_ovr);
`else
    chk("overrun_count", overrun_count, 0);
`endif
    if (m_kind != 0) begin
      p = m_idx % 16;
      if (m_kind == 1) begin
        s  = m_idx / 16;
        ex = (8 + s * 8 + p % 4) % 256;
        ey = (53 + p / 4) % 128;
        ec = m_notes[s] ? 4 : 0;
      end else begin
        ex = 8 + p % 4;
        ey = 46 + p / 4;
        ec = m_col;
      end
      chk("x", x, ex);
      chk("y", y, ey);
      chk("colour", colour, ec);
    end
    if (plot === 1'b1) begin
      log_px.push_back(pk(x, y, colour));
      log_cy.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (flash_ack === 1'b1) ack_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Run until frame_done (kind 0) or flash_ack (kind 1) count reaches target.
  task automatic wait_evt(input int kind, input int target, input int budget);
    int n;
    n = 0;
    while (((kind == 0) ? fd_cnt : ack_cnt) < target && n < budget) begin
      tick();
      if (flash_ack === 1'b1) flash_req = 1'b0;
      n++;
    end
    chk((kind == 0) ? "wait_frame_done" : "wait_flash_ack",
        (((kind == 0) ? fd_cnt : ack_cnt) >= target), 1);
  endtask

  initial begin
    @(posedge clk);
    model_step();
    #1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_ovr", overrun_count, 0);

    // Single lane frame with only slot 0 occupied
    notes = 10'b0000000001;
    base = log_px.size();
    pulse_beat();
    wait_evt(0, fd_cnt + 1, 400);
    chk("lane_count", log_px.size() - base, 160);
    chk("lane_first", log_px[base], pk(8, 53, 4));
    chk("lane_second", log_px[base + 1], pk(9, 53, 4));
    chk("lane_row1", log_px[base + 4], pk(8, 54, 4));
    chk("lane_17th", log_px[base + 16], pk(16, 53, 0));
    chk("lane_last", log_px[base + 159], pk(83, 56, 0));
    chk("lane_fd_lat", fd_cyc - log_cy[base + 159], 1);

    // Flash from idle, request dropped on ack
    tick();
    flash_colour = 3'b010;
    flash_req = 1'b1;
    base = log_px.size();
    wait_evt(1, ack_cnt + 1, 100);
    chk("flash_count", log_px.size() - base, 16);
    chk("flash_first", log_px[base], pk(8, 46, 2));
    chk("flash_last", log_px[base + 15], pk(11, 49, 2));
    tick();
    tick();
    chk("flash_idle", busy, 0);

    // Beat and flash together after reset: lane first, flash back-to-back
    do_reset();
    notes = 10'd0;
    flash_colour = 3'b011;
    base = log_px.size();
    beat = 1'b1;
    flash_req = 1'b1;
    tick();
    beat = 1'b0;
    wait_evt(1, ack_cnt + 1, 500);
    chk("tie_count", log_px.size() - base, 176);
    chk("tie_span", log_cy[base + 175] - log_cy[base], 175);
    chk("tie_lane0", log_px[base], pk(8, 53, 0));
    chk("tie_flash0", log_px[base + 160], pk(8, 46, 3));
    chk("tie_flash15", log_px[base + 175], pk(11, 49, 3));

    // Beats during a lane: one pending, one dropped
    do_reset();
    notes = 10'h200;
    base = log_px.size();
    fd0 = fd_cnt;
    pulse_beat();
    repeat (10) tick();
    pulse_beat();
    repeat (10) tick();
    pulse_beat();
    wait_evt(0, fd0 + 2, 800);
    chk("ovr_count_px", log_px.size() - base, 320);
    chk("ovr_span", log_cy[base + 319] - log_cy[base], 319);
    chk("ovr_last1", log_px[base + 159], pk(83, 56, 4));
    chk("ovr_first2", log_px[base + 160], pk(8, 53, 0));
`ifdef LANE_OVERRUN_CNT_EN
    chk("ovr_value", overrun_count, 1);
`else
    chk("ovr_value", overrun_count, 0);
`endif
    tick();
    chk("ovr_idle", busy, 0);

    // Reset at the 50th lane plot aborts the frame
    do_reset();
    notes = 10'd0;
    base = log_px.size();
    pulse_beat();
    for (int n = 0; n < 100 && (log_px.size() - base) < 49; n++) tick();
    chk("abort_reach", log_px.size() - base, 49);
    fd0 = fd_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    repeat (200) tick();
    chk("abort_no_fd", fd_cnt, fd0);
    base = log_px.size();
    pulse_beat();
    tick();
    chk("abort_restart", log_px[base], pk(8, 53, 0));
    wait_evt(0, fd0 + 1, 400);

    // Notes change mid-frame must not affect the snapshot
    tick();
    notes = 10'b1010000001;
    base = log_px.size();
    fd0 = fd_cnt;
    pulse_beat();
    repeat (30) tick();
    notes = 10'h3FF;
    wait_evt(0, fd0 + 1, 400);
    chk("snap_slot0", log_px[base], pk(8, 53, 4));
    chk("snap_slot1", log_px[base + 16], pk(16, 53, 0));
    chk("snap_slot5", log_px[base + 83], pk(51, 53, 0));
    chk("snap_slot7", log_px[base + 112], pk(64, 53, 4));
    chk("snap_slot9", log_px[base + 159], pk(83, 56, 4));

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
